// File: rtl/mips_multicycle_core_if.sv
// Program-load and debug-read bus of the multi-cycle MIPS core.
// IMEM_DEPTH must match the core it is connected to.
interface mips_multicycle_core_if #(
  parameter int IMEM_DEPTH = 32
);
  logic                          prog_we;
  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr;
  logic [31:0]                   prog_data;
  logic [4:0]                    dbg_raddr;
  logic [31:0]                   dbg_rdata;

  modport master (
    output prog_we, prog_addr, prog_data, dbg_raddr,
    input  dbg_rdata
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, dbg_raddr,
    output dbg_rdata
  );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB/HALT FSM with
// word-addressed instruction and data memories and a debug register port.
module mips_multicycle_core #(
  parameter int IMEM_DEPTH = 32,
  parameter int DMEM_DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  mips_multicycle_core_if.slave   bus,
  output logic [31:0]             pc,
  output logic [2:0]              state,
  output logic                    halted,
  output logic [31:0]             instr_count
);
  localparam int IA = $clog2(IMEM_DEPTH);
  localparam int DA = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5
  } state_e;

  typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_BRANCH, PC_JUMP} pc_sel_e;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09,
                         OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                         OP_XORI  = 6'h0E, OP_LW   = 6'h23, OP_SW   = 6'h2B,
                         OP_HALT  = 6'h3F;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_ADD = 6'h20,
                         F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                         F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26,
                         F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

  state_e         state_q, state_d;
  logic [IA-1:0]  pc_q, pc_d;
  logic [31:0]    ir_q, a_q, b_q, alu_q, mdr_q, count_q;
  logic [31:0]    regs_q [32];
  logic [31:0]    imem [IMEM_DEPTH];
  logic [31:0]    dmem [DMEM_DEPTH];

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] simm, zimm;
  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign funct = ir_q[5:0];
  assign simm  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zimm  = {16'h0000, ir_q[15:0]};

  logic is_lw, is_sw, is_ialu, is_alu_class, br_taken;
  assign is_lw        = (op == OP_LW);
  assign is_sw        = (op == OP_SW);
  assign is_ialu      = (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
                        (op == OP_ANDI) || (op == OP_ORI)   || (op == OP_XORI);
  assign is_alu_class = (op == OP_RTYPE) || is_ialu;
  assign br_taken     = ((op == OP_BEQ) && (a_q == b_q)) ||
                        ((op == OP_BNE) && (a_q != b_q));

  // ALU: result plus a flag saying whether the instruction writes it back
  logic [31:0] alu_res;
  logic        alu_wr;
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_res = '0;
    alu_wr  = 1'b0;
    case (op)
      OP_RTYPE: begin
        alu_wr = 1'b1;
        case (funct)
          F_ADD, F_ADDU: alu_res = a_q + b_q;
          F_SUB, F_SUBU: alu_res = a_q - b_q;
          F_AND:         alu_res = a_q & b_q;
          F_OR:          alu_res = a_q | b_q;
          F_XOR:         alu_res = a_q ^ b_q;
          F_NOR:         alu_res = ~(a_q | b_q);
          F_SLT:         alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
          F_SLTU:        alu_res = {31'b0, a_q < b_q};
          F_SLL:         alu_res = b_q << shamt;
          F_SRL:         alu_res = b_q >> shamt;
          default:       alu_wr  = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin alu_wr = 1'b1; alu_res = a_q + simm; end
      OP_SLTI:  begin alu_wr = 1'b1; alu_res = {31'b0, $signed(a_q) < $signed(simm)}; end
      OP_ANDI:  begin alu_wr = 1'b1; alu_res = a_q & zimm; end
      OP_ORI:   begin alu_wr = 1'b1; alu_res = a_q | zimm; end
      OP_XORI:  begin alu_wr = 1'b1; alu_res = a_q ^ zimm; end
      OP_LW, OP_SW: alu_res = a_q + simm;
      default: ;
    endcase
  end

  // Write-back target: rd for R-type, rt otherwise; register 0 never written
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  assign rf_waddr = (op == OP_RTYPE) ? rd : rt;
  assign rf_wdata = is_lw ? mdr_q : alu_q;

  // FSM control: next state, PC source and per-cycle enables
  logic ir_ld, ab_ld, alu_ld, mdr_ld, cnt_inc, rf_we, dmem_we;
  pc_sel_e pc_sel;
  always_comb begin
    state_d = state_q;
    pc_sel  = PC_HOLD;
    ir_ld   = 1'b0;
    ab_ld   = 1'b0;
    alu_ld  = 1'b0;
    mdr_ld  = 1'b0;
    cnt_inc = 1'b0;
    rf_we   = 1'b0;
    dmem_we = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_ld   = 1'b1;
        pc_sel  = PC_INC;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ab_ld   = 1'b1;
        state_d = (op == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_ld = 1'b1;
        if (is_alu_class) begin
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          // Branch, jump or undefined opcode: retires here
          state_d = S_FETCH;
          cnt_inc = 1'b1;
          if (op == OP_J)    pc_sel = PC_JUMP;
          else if (br_taken) pc_sel = PC_BRANCH;
        end
      end
      S_MEM: begin
        if (is_lw) begin
          mdr_ld  = 1'b1;
          state_d = S_WB;
        end else begin
          dmem_we = 1'b1;
          cnt_inc = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        rf_we   = (alu_wr || is_lw) && (rf_waddr != 5'd0);
        cnt_inc = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    case (pc_sel)
      PC_INC:    pc_d = pc_q + IA'(1);
      PC_BRANCH: pc_d = pc_q + simm[IA-1:0];
      PC_JUMP:   pc_d = ir_q[IA-1:0];
      default:   pc_d = pc_q;
    endcase
  end

  // FSM state register
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Datapath registers and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      count_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (ir_ld)   ir_q    <= imem[pc_q];
      if (ab_ld)   begin a_q <= regs_q[rs]; b_q <= regs_q[rt]; end
      if (alu_ld)  alu_q   <= alu_res;
      if (mdr_ld)  mdr_q   <= dmem[alu_q[DA-1:0]];
      if (cnt_inc) count_q <= count_q + 32'd1;
    end
  end

  // Register file: cleared by reset, written only in WB
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Instruction memory: loader writes accepted only in reset or halt
  // NOTE: memories have no reset; their contents must survive rst.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (rst || (state_q == S_HALT)))
      imem[bus.prog_addr] <= bus.prog_data;
  end

  // Data memory: sw store, suppressed on a reset edge
  always_ff @(posedge clk) begin
    if (dmem_we && !rst)
      dmem[alu_q[DA-1:0]] <= b_q;
  end

  assign bus.dbg_rdata = (bus.dbg_raddr == 5'd0) ? 32'd0 : regs_q[bus.dbg_raddr];
  assign pc            = 32'(pc_q);
  assign state         = state_q;
  assign halted        = (state_q == S_HALT);
  assign instr_count   = count_q;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: table of small programs
// with a scoreboard of expected end states, plus hand-written sequences.
module tb_mips_multicycle_core;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  always #5 clk = ~clk;

  mips_multicycle_core_if #(.IMEM_DEPTH(32)) bus ();
  mips_multicycle_core_if #(.IMEM_DEPTH(4))  bus4 ();

  logic [31:0] pc, instr_count, pc4, instr_count4;
  logic [2:0]  state, state4;
  logic        halted, halted4;

  mips_multicycle_core #(.IMEM_DEPTH(32), .DMEM_DEPTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pc(pc), .state(state),
    .halted(halted), .instr_count(instr_count)
  );

  mips_multicycle_core #(.IMEM_DEPTH(4), .DMEM_DEPTH(32)) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4), .pc(pc4), .state(state4),
    .halted(halted4), .instr_count(instr_count4)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input logic [4:0] rs_f, rt_f, rd_f, sh, input logic [5:0] fn);
    return {6'h00, rs_f, rt_f, rd_f, sh, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] opc, input logic [4:0] rs_f, rt_f, input logic [15:0] imm);
    return {opc, rs_f, rt_f, imm};
  endfunction

  typedef struct {
    string           name;
    logic [3:0][31:0] prog;
    logic [4:0]      chk_reg;
    logic [31:0]     exp_val;
    int              exp_count;
    int              exp_pc;
    int              exp_cycles;
  } vec_t;

  typedef struct {
    string       name;
    logic [4:0]  chk_reg;
    logic [31:0] exp_val;
    int          exp_count;
    int          exp_pc;
    int          exp_cycles;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic add_vec(input string nm, input logic [31:0] i0, i1, i2, i3,
                         input logic [4:0] r, input logic [31:0] val,
                         input int cnt, pcv, cyc);
    vec_t v;
    v.name = nm;
    v.prog[0] = i0; v.prog[1] = i1; v.prog[2] = i2; v.prog[3] = i3;
    v.chk_reg = r; v.exp_val = val; v.exp_count = cnt; v.exp_pc = pcv; v.exp_cycles = cyc;
    vecs.push_back(v);
  endtask

  // Hold reset, write the whole imem (unused words = halt), then release
  task automatic load_and_release(input logic [3:0][31:0] p);
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      bus.prog_we   = 1'b1;
      bus.prog_addr = 5'(a);
      bus.prog_data = (a < 4) ? p[a] : HALT;
    end
    @(negedge clk);
    bus.prog_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    bus.dbg_raddr = r;
    #1;
    v = bus.dbg_rdata;
  endtask

  initial begin
    int cyc;
    logic [31:0] rv;
    logic [3:0][31:0] p;
    exp_t e;
    logic [2:0] st_q[$];

    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0; bus.dbg_raddr = '0;
    bus4.prog_we = 1'b0; bus4.prog_addr = '0; bus4.prog_data = '0; bus4.dbg_raddr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {29'b0, state}, 32'd0);
    check("reset_pc", pc, 32'd0);
    check("reset_count", instr_count, 32'd0);
    check("reset_halted", {31'b0, halted}, 32'd0);

    add_vec("add_prog", i_op(6'h08,0,1,16'd5), i_op(6'h08,0,2,16'd7), r_op(1,2,3,0,6'h20), HALT, 5'd3, 32'd12, 3, 4, 14);
    add_vec("sw_lw", i_op(6'h08,0,1,16'h1234), i_op(6'h2B,0,1,16'd3), i_op(6'h23,0,2,16'd3), HALT, 5'd2, 32'h1234, 3, 4, 15);
    add_vec("beq_taken", i_op(6'h08,0,1,16'd1), i_op(6'h04,1,1,16'd1), i_op(6'h08,0,2,16'd9), HALT, 5'd2, 32'd0, 2, 4, 9);
    add_vec("bne_not_taken", i_op(6'h08,0,1,16'd1), i_op(6'h05,1,1,16'd1), i_op(6'h08,0,2,16'd9), HALT, 5'd2, 32'd9, 3, 4, 13);
    add_vec("write_r0", i_op(6'h08,0,0,16'd9), HALT, HALT, HALT, 5'd0, 32'd0, 1, 2, 6);
    add_vec("sll", i_op(6'h08,0,1,16'd3), r_op(0,1,4,4,6'h00), HALT, HALT, 5'd4, 32'd48, 2, 3, 10);
    add_vec("slt", i_op(6'h08,0,1,16'hFFFF), i_op(6'h08,0,2,16'd1), r_op(1,2,3,0,6'h2A), HALT, 5'd3, 32'd1, 3, 4, 14);
    add_vec("sltu", i_op(6'h08,0,1,16'hFFFF), i_op(6'h08,0,2,16'd1), r_op(1,2,3,0,6'h2B), HALT, 5'd3, 32'd0, 3, 4, 14);
    add_vec("sub", i_op(6'h08,0,1,16'd5), i_op(6'h08,0,2,16'd7), r_op(1,2,3,0,6'h22), HALT, 5'd3, 32'hFFFF_FFFE, 3, 4, 14);
    add_vec("ori_zext", i_op(6'h0D,0,1,16'h8000), HALT, HALT, HALT, 5'd1, 32'h0000_8000, 1, 2, 6);
    add_vec("addi_sext", i_op(6'h08,0,1,16'h8000), HALT, HALT, HALT, 5'd1, 32'hFFFF_8000, 1, 2, 6);
    add_vec("nor", r_op(0,0,3,0,6'h27), HALT, HALT, HALT, 5'd3, 32'hFFFF_FFFF, 1, 2, 6);
    add_vec("jump", {6'h02, 26'd2}, i_op(6'h08,0,1,16'd9), HALT, HALT, 5'd1, 32'd0, 1, 3, 5);
    add_vec("undef_op", i_op(6'h3E,0,1,16'd5), HALT, HALT, HALT, 5'd1, 32'd0, 1, 2, 5);
    add_vec("undef_funct", i_op(6'h08,0,1,16'd5), r_op(1,1,1,0,6'h3F), HALT, HALT, 5'd1, 32'd5, 2, 3, 10);
    add_vec("srl", i_op(6'h08,0,1,16'hFFF0), r_op(0,1,2,4,6'h02), HALT, HALT, 5'd2, 32'h0FFF_FFFF, 2, 3, 10);
    add_vec("andi", i_op(6'h08,0,1,16'h000C), i_op(6'h0C,1,2,16'h000A), HALT, HALT, 5'd2, 32'd8, 2, 3, 10);
    add_vec("xori_zext", i_op(6'h08,0,1,16'h000C), i_op(6'h0E,1,2,16'hFFFF), HALT, HALT, 5'd2, 32'h0000_FFF3, 2, 3, 10);
    add_vec("slti", i_op(6'h08,0,1,16'hFFFF), i_op(6'h0A,1,2,16'd0), HALT, HALT, 5'd2, 32'd1, 2, 3, 10);
    add_vec("bne_loop", i_op(6'h08,0,2,16'd3), i_op(6'h08,1,1,16'd1), i_op(6'h05,1,2,16'hFFFE), HALT, 5'd1, 32'd3, 7, 4, 27);

    // Table-driven programs: expected end state goes on the scoreboard at release
    foreach (vecs[k]) begin
      load_and_release(vecs[k].prog);
      e.name = vecs[k].name; e.chk_reg = vecs[k].chk_reg; e.exp_val = vecs[k].exp_val;
      e.exp_count = vecs[k].exp_count; e.exp_pc = vecs[k].exp_pc; e.exp_cycles = vecs[k].exp_cycles;
      sb.push_back(e);
      run_to_halt(cyc);
      e = sb.pop_front();
      check({e.name, "_halted"}, {31'b0, halted}, 32'd1);
      check({e.name, "_cycles"}, 32'(cyc), 32'(e.exp_cycles));
      read_reg(e.chk_reg, rv);
      check({e.name, "_reg"}, rv, e.exp_val);
      check({e.name, "_count"}, instr_count, 32'(e.exp_count));
      check({e.name, "_pc"}, pc, 32'(e.exp_pc));
    end

    // lw occupies exactly five cycles: F,D,E,M,WB then the halt's fetch
    load_and_release(vecs[1].prog);
    repeat (8) @(posedge clk);
    #1;
    st_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    while (st_q.size() > 0) begin
      check("lw_state_seq", {29'b0, state}, {29'b0, st_q.pop_front()});
      @(posedge clk);
      #1;
    end

    // Reset during EXEC of the add, then rerun from the intact imem
    load_and_release(vecs[0].prog);
    repeat (10) @(posedge clk);
    #1;
    check("mid_exec_state", {29'b0, state}, 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_state", {29'b0, state}, 32'd0);
    check("mid_rst_pc", pc, 32'd0);
    check("mid_rst_count", instr_count, 32'd0);
    read_reg(5'd1, rv);
    check("mid_rst_reg1", rv, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_to_halt(cyc);
    check("rerun_cycles", 32'(cyc), 32'd14);
    read_reg(5'd3, rv);
    check("rerun_reg3", rv, 32'd12);

    // imem write while halted is honoured: replace the add with halt
    @(negedge clk);
    bus.prog_we = 1'b1; bus.prog_addr = 5'd2; bus.prog_data = HALT;
    @(negedge clk);
    bus.prog_we = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_to_halt(cyc);
    check("halt_write_cycles", 32'(cyc), 32'd10);
    check("halt_write_count", instr_count, 32'd2);
    read_reg(5'd2, rv);
    check("halt_write_reg2", rv, 32'd7);
    read_reg(5'd3, rv);
    check("halt_write_reg3", rv, 32'd0);

    // Store in flight on a reset edge is suppressed (dmem[3] keeps 0x1234)
    p[0] = i_op(6'h08,0,1,16'h0077); p[1] = i_op(6'h2B,0,1,16'd3); p[2] = HALT; p[3] = HALT;
    load_and_release(p);
    repeat (7) @(posedge clk);
    #1;
    check("sw_mem_state", {29'b0, state}, 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    p[0] = i_op(6'h23,0,2,16'd3); p[1] = HALT;
    load_and_release(p);
    run_to_halt(cyc);
    read_reg(5'd2, rv);
    check("sw_suppressed", rv, 32'h1234);

    // IMEM_DEPTH=4: pc wraps, prog_we while running is ignored
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      bus4.prog_we = 1'b1; bus4.prog_addr = 2'(a); bus4.prog_data = i_op(6'h08,1,1,16'd1);
    end
    @(negedge clk);
    bus4.prog_we = 1'b0;
    @(negedge clk);
    rst4 = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      bus4.prog_we = 1'b1; bus4.prog_addr = 2'(c % 4); bus4.prog_data = HALT;
      @(posedge clk);
      #1;
      if (c == 12) check("wrap_pc_before", pc4, 32'd3);
      if (c == 13) check("wrap_pc_after", pc4, 32'd0);
      @(negedge clk);
    end
    bus4.prog_we = 1'b0;
    bus4.dbg_raddr = 5'd1;
    #1;
    check("wrap_reg1_6", bus4.dbg_rdata, 32'd6);
    check("wrap_count_6", instr_count4, 32'd6);
    repeat (8) @(posedge clk);
    #1;
    check("wrap_not_halted", {31'b0, halted4}, 32'd0);
    check("wrap_reg1_8", bus4.dbg_rdata, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_core.md
MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 Parameter IMEM_DEPTH, default 32, instruction memory words; SHALL be a power of 2, 2..1024.
REQ-002 Parameter DMEM_DEPTH, default 32, data memory words; SHALL be a power of 2, 2..1024.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 prog_we  in  1  instruction memory write enable; SHALL be honoured only while rst=1 or halted=1.
REQ-006 prog_addr  in  clog2(IMEM_DEPTH)  instruction memory write address.
REQ-007 prog_data  in  32  instruction word to write.
REQ-008 dbg_raddr  in  5  register file debug read index.
REQ-009 dbg_rdata  out  32  combinational regs[dbg_raddr]; index 0 SHALL read 0.
REQ-010 pc  out  32  current PC, word address, zero-extended.
REQ-011 state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-012 halted  out  1  high iff state==HALT.
REQ-013 instr_count  out  32  retired-instruction counter.

Function
REQ-014 Multi-cycle FSM: FETCH SHALL latch IR<=imem[pc] and set pc<=pc+1 modulo IMEM_DEPTH.
REQ-015 DECODE SHALL latch A<=regs[IR[25:21]], B<=regs[IR[20:16]]; opcode 6'h3F SHALL go to HALT, all else to EXEC.
REQ-016 Cycles per instruction: R-type/I-ALU 4 (F,D,E,WB); lw 5 (F,D,E,M,WB); sw 4 (F,D,E,M); beq/bne/j 3 (F,D,E); undefined opcode 3 (F,D,E, no architectural effect).
REQ-017 R-type funct: add/addu 0x20/0x21, sub/subu 0x22/0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A signed, sltu 0x2B unsigned, sll 0x00, srl 0x02; shifts SHALL use B and shamt IR[10:6]; other funct SHALL write nothing.
REQ-018 I-type: addi/addiu 0x08/0x09 and slti 0x0A use sign-extended imm; andi 0x0C, ori 0x0D, xori 0x0E use zero-extended imm; destination IR[20:16].
REQ-019 R-type destination IR[15:11]; writes to register 0 SHALL be discarded.
REQ-020 lw 0x23 / sw 0x2B: address = (A + sext(imm)) modulo DMEM_DEPTH, word-addressed; lw SHALL latch data in MEM and write rt in WB; sw SHALL write B in MEM.
REQ-021 beq 0x04 / bne 0x05: taken condition evaluated in EXEC; taken SHALL set pc<=(pc + sext(imm)) modulo IMEM_DEPTH, pc already incremented; not taken leaves pc.
REQ-022 j 0x02: pc<=IR[25:0] modulo IMEM_DEPTH in EXEC.
REQ-023 instr_count SHALL increment by 1, wrapping at 2^32, on the final cycle of every non-halt instruction, undefined opcodes included; halt SHALL not count.
REQ-024 HALT SHALL be absorbing until rst; pc SHALL hold the address after the halt word.
REQ-025 Data memory and register file SHALL be synchronous-write; register writes SHALL occur only in WB.
REQ-026 prog_we asserted while running (rst=0, halted=0) SHALL be ignored.

Reset
REQ-027 rst=1 SHALL, on the next edge, set state=FETCH, pc=0, IR=0, instr_count=0, all 32 registers 0, from any state including mid-instruction.
REQ-028 Reset SHALL NOT alter instruction or data memory contents; a write in flight on the reset edge SHALL be suppressed.
REQ-029 First FETCH SHALL occur on the first edge with rst=0.

Verification
REQ-030 Program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; halt -> $3=12, halted=1 on edge 14 after reset release, instr_count=3, pc=4.
REQ-031 addi $1,$0,0x1234; sw $1,3($0); lw $2,3($0); halt -> $2=0x1234; lw occupies exactly 5 cycles with state sequence 0,1,2,3,4.
REQ-032 addi $1,$0,1; beq $1,$1,+1; addi $2,$0,9; halt -> $2=0, instr_count=2; same with bne -> $2=9, instr_count=3.
REQ-033 addi $0,$0,9; sll $4,$1,4 with $1=3; slt with $1=-1,$2=1 -> $0=0, $4=48, slt result 1, sltu result 0.
REQ-034 rst asserted one edge while state=EXEC of an add -> next state FETCH, pc=0, registers 0, imem intact, program reruns to same result.
REQ-035 IMEM_DEPTH=4, imem all addi $1,$1,1 -> pc wraps 3->0, after 6 instructions $1=6; prog_we during run leaves imem unchanged.
